fft_bitrev_reorder: RTL
=======================

Name: fft_bitrev_reorder

Overview:
- Output reorder buffer placed directly downstream of the last radix-2 SDF butterfly stage (stage 5, WN = 1+0j) of the 32-point FFT.
- The butterfly chain emits each frame's 32 bins in bit-reversed order. This block re-sequences them into natural order X[0]..X[31].
- Ping-pong double buffering lets back-to-back frames stream with no stall and no backpressure.

Parameters:
- N, 32, FFT length (power of 2)
- LOGN, 5, log2(N); width of index counters
- DW, 17, sample width per component; signed, 11-bit integer, 6-bit fraction (matches last-stage butterfly output)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_r/in_i carry one bin this cycle
- in_r  in  DW  real part of bin, bit-reversed arrival order
- in_i  in  DW  imaginary part of bin
- out_valid  out  1  out_r/out_i/out_idx valid this cycle
- out_r  out  DW  real part, natural order
- out_i  out  DW  imaginary part, natural order
- out_idx  out  LOGN  bin index of current output (0..N-1)
- out_last  out  1  high with out_idx = N-1
- frame_in_done  out  1  one-cycle pulse on the cycle the N-th sample of a frame is written

Behaviour:
- Reset (async, rst=1): wr_cnt=0, wr_bank=0, rd_cnt=0, rd_bank=0, read FSM=R_IDLE, bank_full[1:0]=0. All outputs are 0: out_valid, out_r, out_i, out_idx, out_last, frame_in_done. Memory contents are don't-care.
- Storage: two banks of N complex words (2*DW bits each). Memory is inferred as registers; no reset on memory.
- Write side:
  - On each clk with in_valid=1: mem[wr_bank][bitrev(wr_cnt)] <= {in_r,in_i}, then wr_cnt++.
  - bitrev reverses LOGN bits, e.g. 1 -> 16, 3 -> 24.
  - in_valid=0 holds wr_cnt; gaps within a frame are allowed.
  - When wr_cnt=N-1 and in_valid=1: wr_cnt wraps to 0, bank_full[wr_bank] is set, wr_bank toggles, frame_in_done pulses next cycle.
- Read FSM:
  - R_IDLE: when bank_full[rd_bank]=1, go to R_BUSY with rd_cnt=0.
  - R_BUSY: each cycle, register out_r/out_i from mem[rd_bank][rd_cnt]; out_idx=rd_cnt, out_valid=1, out_last=(rd_cnt==N-1); then rd_cnt++.
  - On rd_cnt=N-1: clear bank_full[rd_bank] and toggle rd_bank. If bank_full of the new rd_bank is already 1, stay in R_BUSY with rd_cnt=0 (seamless, no bubble). Otherwise go to R_IDLE.
  - out_valid=0 in R_IDLE; out_r/out_i/out_idx hold their last values.
- Latency: if the N-th sample is written at edge t, out_idx=0 is valid after edge t+2. Bins are then emitted on N consecutive cycles.
- Throughput: one frame per N cycles sustained. A write can never reach a bank still being read, because reading takes exactly N cycles and writing at least N cycles.
- Simultaneous set and clear of bank_full on the same bank cannot happen. Set of one bank and clear of the other in the same cycle are both applied.
- rst asserted mid-frame: partial input frame and any in-progress output are discarded; operation restarts from the reset state.
- No arithmetic is performed; data passes bit-exact.

Test Plan:
- Single frame, continuous: feed in_r=k, in_i=-k at arrival k=0..31 -> out_idx n carries in_r=bitrev(n), e.g. out_idx=1 gives out_r=16, out_i=-16; out_idx=3 gives out_r=24. out_valid is high for 32 consecutive cycles starting 2 cycles after the last input; out_last is high only at out_idx=31.
- Back-to-back frames: 4 frames streamed contiguously with a frame tag in the top bits -> 128 contiguous out_valid cycles, no bubbles, tags in order, each frame correctly reordered.
- Gapped input: in_valid toggles 1,0,1,0 within a frame -> output sequence identical to the continuous case. The output start is referenced to the 32nd accepted sample.
- Reset mid-frame: assert rst after 10 samples, then feed a full frame -> no out_valid until 2 cycles after the new frame's 32nd sample; only new-frame data appears.
- Reset during output: assert rst at out_idx=12 -> out_valid=0 and all outputs 0 immediately (asynchronous); a subsequent frame is reordered correctly.
- Extreme values: bins of 0x0FFFF/0x10000 (max/min signed 17-bit) -> passed bit-exact, sign preserved.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// Output reorder buffer for the 32-point SDF FFT: converts bit-reversed bin
// order from the last butterfly stage into natural order X[0]..X[N-1] using
// ping-pong banks so consecutive frames stream without stalls.
module fft_bitrev_reorder #(
  parameter int unsigned N    = 32,
  parameter int unsigned LOGN = 5,
  parameter int unsigned DW   = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_r,
  input  logic [DW-1:0]   in_i,
  output logic            out_valid,
  output logic [DW-1:0]   out_r,
  output logic [DW-1:0]   out_i,
  output logic [LOGN-1:0] out_idx,
  output logic            out_last,
  output logic            frame_in_done
);

  localparam int unsigned MW = 2 * DW;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rstate_e;

  // Reverse the LOGN index bits (arrival position -> natural bin index).
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int b = 0; b < int'(LOGN); b++) begin
      r[b] = a[int'(LOGN) - 1 - b];
    end
    return r;
  endfunction

  // Two banks of N complex words; contents are don't-care after reset.
  logic [MW-1:0]   mem_q [2][N];

  logic [LOGN-1:0] wr_cnt_q, wr_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic [1:0]      bank_full_q, bank_full_d;
  logic            frame_in_done_q, frame_in_done_d;
  rstate_e         state_q, state_d;
  logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_r_q, out_r_d;
  logic [DW-1:0]   out_i_q, out_i_d;
  logic [LOGN-1:0] out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;

  logic            wr_done_c;
  logic            rd_done_c;
  logic [MW-1:0]   rd_word_c;

  assign wr_done_c = in_valid && (wr_cnt_q == LOGN'(N - 1));
  assign rd_done_c = (state_q == R_BUSY) && (rd_cnt_q == LOGN'(N - 1));
  assign rd_word_c = mem_q[rd_bank_q][rd_cnt_q];

  // Store each incoming bin at its bit-reversed (natural) address.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_q[wr_bank_q][bitrev(wr_cnt_q)] <= {in_r, in_i};
    end
  end

  // Write-side counter, bank select and frame-complete pulse.
  always_comb begin
    wr_cnt_d        = wr_cnt_q;
    wr_bank_d       = wr_bank_q;
    frame_in_done_d = 1'b0;
    if (in_valid) begin
      wr_cnt_d = wr_cnt_q + LOGN'(1);
    end
    if (wr_done_c) begin
      wr_bank_d       = ~wr_bank_q;
      frame_in_done_d = 1'b1;
    end
  end

  // Read FSM next-state, bank ownership and registered output values.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    bank_full_d = bank_full_q;
    out_valid_d = 1'b0;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_idx_d   = out_idx_q;
    out_last_d  = 1'b0;

    // Writer and reader never own the same bank, so set/clear never collide.
    if (wr_done_c) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end

    case (state_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = R_BUSY;
          rd_cnt_d = '0;
        end
      end
      R_BUSY: begin
        out_valid_d = 1'b1;
        out_r_d     = rd_word_c[MW-1:DW];
        out_i_d     = rd_word_c[DW-1:0];
        out_idx_d   = rd_cnt_q;
        out_last_d  = rd_done_c;
        rd_cnt_d    = rd_cnt_q + LOGN'(1);
        if (rd_done_c) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = ~rd_bank_q;
          rd_cnt_d               = '0;
          // Next frame already waiting: continue without a bubble.
          if (!bank_full_q[~rd_bank_q]) begin
            state_d = R_IDLE;
          end
        end
      end
      default: begin
        state_d = R_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q        <= '0;
      wr_bank_q       <= 1'b0;
      bank_full_q     <= 2'b00;
      frame_in_done_q <= 1'b0;
      state_q         <= R_IDLE;
      rd_cnt_q        <= '0;
      rd_bank_q       <= 1'b0;
      out_valid_q     <= 1'b0;
      out_r_q         <= '0;
      out_i_q         <= '0;
      out_idx_q       <= '0;
      out_last_q      <= 1'b0;
    end else begin
      wr_cnt_q        <= wr_cnt_d;
      wr_bank_q       <= wr_bank_d;
      bank_full_q     <= bank_full_d;
      frame_in_done_q <= frame_in_done_d;
      state_q         <= state_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_bank_q       <= rd_bank_d;
      out_valid_q     <= out_valid_d;
      out_r_q         <= out_r_d;
      out_i_q         <= out_i_d;
      out_idx_q       <= out_idx_d;
      out_last_q      <= out_last_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_r         = out_r_q;
  assign out_i         = out_i_q;
  assign out_idx       = out_idx_q;
  assign out_last      = out_last_q;
  assign frame_in_done = frame_in_done_q;

endmodule
